obi_resp_model: RTL and testbench

- Parametrised OBI (Open Bus Interface) responder and environment model for formal and simulation harnesses around CV32E40P-class cores.
- Replaces ad-hoc pending-transaction counters and assumptions with one reusable block that serves NUM_CH independent channels (e.g. instr + data).
- Per channel it:
  - generates grants;
  - tracks outstanding transactions in order, up to a configurable depth;
  - enforces a minimum response latency;
  - returns responses with externally supplied (free/random) data and error;
  - flags requester protocol violations.

---
 rtl/obi_model_pkg.sv | 21 ++
 rtl/obi_resp_chan.sv | 97 +++++++++
 rtl/obi_resp_model.sv | 59 +++++
 tb/tb_obi_resp_model.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/obi_model_pkg.sv
// Shared types and helpers for the OBI responder model.
package obi_model_pkg;

    localparam int CNT_W  = 4;
    localparam int PTR_W  = 3;
    localparam int ENT_AW = 32;
    localparam int ENT_DW = 32;

    typedef struct packed {
        logic [ENT_AW-1:0]   addr;
        logic                we;
        logic [ENT_DW/8-1:0] be;
    } obi_req_entry_t;

    // Advance a FIFO index, wrapping at an arbitrary (not necessarily 2^n) depth.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx, input int depth);
        if (int'(idx) >= depth - 1) return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/obi_resp_chan.sv
// One OBI channel: in-order outstanding FIFO with per-entry latency aging,
// grant/response generation and a requester protocol checker.
module obi_resp_chan
    import obi_model_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_PND = 2,
    parameter int MIN_LAT = 1,
    parameter int ERR_EN  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [AW-1:0]    addr,
    input  logic             we,
    input  logic [DW/8-1:0]  be,
    input  logic             gnt_en,
    input  logic             rsp_en,
    input  logic [DW-1:0]    rand_rdata,
    input  logic             rand_err,
    output logic             gnt,
    output logic             rvalid,
    output logic [DW-1:0]    rdata,
    output logic             err,
    output logic [CNT_W-1:0] pnd_cnt,
    output logic [AW-1:0]    rsp_addr,
    output logic             rsp_we,
    output logic             proto_err
);

    localparam int PW   = (MAX_PND > 1) ? $clog2(MAX_PND) : 1;
    localparam int SLOTS = 1 << PW;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_PND);
    // Stored age counts cycles after the grant cycle, so MIN_LAT-1 means "old enough".
    localparam logic [2:0] LAT_M1 = 3'(MIN_LAT - 1);

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            we;
        logic [DW/8-1:0] be;
    } entry_t;

    entry_t           mem [SLOTS];
    logic [2:0]       age [SLOTS];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    entry_t           cur, prev, head;
    logic             pend, empty;

    assign cur   = {addr, we, be};
    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);

    assign gnt      = !reset && req && gnt_en && (cnt < DEPTH);
    assign rvalid   = !empty && rsp_en && (age[rd_ptr] == LAT_M1);
    assign rdata    = (rvalid && !head.we) ? rand_rdata : '0;
    assign err      = (ERR_EN != 0) && rvalid && rand_err;
    assign rsp_addr = empty ? '0 : head.addr;
    assign rsp_we   = !empty && head.we;
    assign pnd_cnt  = cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            pend      <= 1'b0;
            prev      <= '0;
            proto_err <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
                age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++)
                if (age[i] != LAT_M1) age[i] <= age[i] + 3'd1;
            if (gnt) begin
                mem[wr_ptr] <= cur;
                age[wr_ptr] <= '0;
                wr_ptr      <= PW'(wrap_inc(PTR_W'(wr_ptr), MAX_PND));
            end
            if (rvalid)
                rd_ptr <= PW'(wrap_inc(PTR_W'(rd_ptr), MAX_PND));
            case ({gnt, rvalid})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // An ungranted request must be held stable until it is granted.
            if (pend && (!req || cur != prev)) proto_err <= 1'b1;
            pend <= req && !gnt;
            prev <= cur;
        end
    end

endmodule

// File: rtl/obi_resp_model.sv
// Multi-channel OBI responder model: NUM_CH independent obi_resp_chan instances.
module obi_resp_model
    import obi_model_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_PND = 2,
    parameter int MIN_LAT = 1,
    parameter int ERR_EN  = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req_i,
    input  logic [NUM_CH*AW-1:0]    addr_i,
    input  logic [NUM_CH-1:0]       we_i,
    input  logic [NUM_CH*DW/8-1:0]  be_i,
    output logic [NUM_CH-1:0]       gnt_o,
    output logic [NUM_CH-1:0]       rvalid_o,
    output logic [NUM_CH*DW-1:0]    rdata_o,
    output logic [NUM_CH-1:0]       err_o,
    input  logic [NUM_CH-1:0]       gnt_en_i,
    input  logic [NUM_CH-1:0]       rsp_en_i,
    input  logic [NUM_CH*DW-1:0]    rand_rdata_i,
    input  logic [NUM_CH-1:0]       rand_err_i,
    output logic [NUM_CH*CNT_W-1:0] pnd_cnt_o,
    output logic [NUM_CH*AW-1:0]    rsp_addr_o,
    output logic [NUM_CH-1:0]       rsp_we_o,
    output logic [NUM_CH-1:0]       proto_err_o
);

    localparam int BW = DW / 8;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        obi_resp_chan #(
            .AW(AW), .DW(DW), .MAX_PND(MAX_PND), .MIN_LAT(MIN_LAT), .ERR_EN(ERR_EN)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .req        (req_i[c]),
            .addr       (addr_i[c*AW +: AW]),
            .we         (we_i[c]),
            .be         (be_i[c*BW +: BW]),
            .gnt_en     (gnt_en_i[c]),
            .rsp_en     (rsp_en_i[c]),
            .rand_rdata (rand_rdata_i[c*DW +: DW]),
            .rand_err   (rand_err_i[c]),
            .gnt        (gnt_o[c]),
            .rvalid     (rvalid_o[c]),
            .rdata      (rdata_o[c*DW +: DW]),
            .err        (err_o[c]),
            .pnd_cnt    (pnd_cnt_o[c*CNT_W +: CNT_W]),
            .rsp_addr   (rsp_addr_o[c*AW +: AW]),
            .rsp_we     (rsp_we_o[c]),
            .proto_err  (proto_err_o[c])
        );
    end

endmodule

// File: tb/tb_obi_resp_model.sv
// Bench for obi_resp_model: two configurations (lanes 0,1 = 2-ch MAX_PND=2 MIN_LAT=1 ERR_EN=0;
// lane 2 = 1-ch MAX_PND=3 MIN_LAT=3 ERR_EN=1) against a timestamp/queue reference model.
module tb_obi_resp_model;

    localparam int NL = 3;
    int maxp  [NL] = '{2, 2, 3};
    int minl  [NL] = '{1, 1, 3};
    int erren [NL] = '{0, 0, 1};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        req [NL], we [NL], gen [NL], ren [NL], rerr [NL];
    logic [31:0] addr [NL], rdat [NL];
    logic [3:0]  be [NL];

    logic        o_gnt [NL], o_rv [NL], o_err [NL], o_rwe [NL], o_perr [NL];
    logic [31:0] o_rdata [NL], o_raddr [NL];
    logic [3:0]  o_cnt [NL];

    logic [1:0]  a_gnt, a_rv, a_err, a_rwe, a_perr;
    logic [63:0] a_rdata, a_raddr;
    logic [7:0]  a_cnt;
    logic        b_gnt, b_rv, b_err, b_rwe, b_perr;
    logic [31:0] b_rdata, b_raddr;
    logic [3:0]  b_cnt;

    obi_resp_model #(.NUM_CH(2), .MAX_PND(2), .MIN_LAT(1), .ERR_EN(0)) dut_a (
        .clock(clock), .reset(reset),
        .req_i({req[1], req[0]}), .addr_i({addr[1], addr[0]}), .we_i({we[1], we[0]}),
        .be_i({be[1], be[0]}), .gnt_o(a_gnt), .rvalid_o(a_rv), .rdata_o(a_rdata), .err_o(a_err),
        .gnt_en_i({gen[1], gen[0]}), .rsp_en_i({ren[1], ren[0]}),
        .rand_rdata_i({rdat[1], rdat[0]}), .rand_err_i({rerr[1], rerr[0]}),
        .pnd_cnt_o(a_cnt), .rsp_addr_o(a_raddr), .rsp_we_o(a_rwe), .proto_err_o(a_perr)
    );

    obi_resp_model #(.NUM_CH(1), .MAX_PND(3), .MIN_LAT(3), .ERR_EN(1)) dut_b (
        .clock(clock), .reset(reset),
        .req_i(req[2]), .addr_i(addr[2]), .we_i(we[2]), .be_i(be[2]),
        .gnt_o(b_gnt), .rvalid_o(b_rv), .rdata_o(b_rdata), .err_o(b_err),
        .gnt_en_i(gen[2]), .rsp_en_i(ren[2]), .rand_rdata_i(rdat[2]), .rand_err_i(rerr[2]),
        .pnd_cnt_o(b_cnt), .rsp_addr_o(b_raddr), .rsp_we_o(b_rwe), .proto_err_o(b_perr)
    );

    for (genvar l = 0; l < 2; l++) begin : g_obs
        assign o_gnt[l]   = a_gnt[l];
        assign o_rv[l]    = a_rv[l];
        assign o_err[l]   = a_err[l];
        assign o_rwe[l]   = a_rwe[l];
        assign o_perr[l]  = a_perr[l];
        assign o_rdata[l] = a_rdata[l*32 +: 32];
        assign o_raddr[l] = a_raddr[l*32 +: 32];
        assign o_cnt[l]   = a_cnt[l*4 +: 4];
    end
    assign o_gnt[2] = b_gnt;     assign o_rv[2] = b_rv;       assign o_err[2] = b_err;
    assign o_rwe[2] = b_rwe;     assign o_perr[2] = b_perr;   assign o_rdata[2] = b_rdata;
    assign o_raddr[2] = b_raddr; assign o_cnt[2] = b_cnt;

    // Reference model: each outstanding transaction remembers the cycle it was granted.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        int          g;
    } txn_t;

    txn_t        q [NL][$];
    bit          proto_m [NL], pend_m [NL], egs [NL], evs [NL];
    logic [36:0] prev_m [NL];
    int          checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string tag, input int l, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lane%0d cyc%0d observed=%0h expected=%0h", tag, l, cyc, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already applied; checks, then advances one clock.
    task automatic step();
        txn_t h;
        bit   ne;
        #3;
        for (int l = 0; l < NL; l++) begin
            if (reset) begin
                q[l].delete();
                proto_m[l] = 0;
                pend_m[l]  = 0;
            end
            ne = q[l].size() > 0;
            h  = ne ? q[l][0] : '{addr: 0, we: 0, be: 0, g: 0};
            egs[l] = !reset && req[l] && gen[l] && (q[l].size() < maxp[l]);
            evs[l] = ne && ren[l] && (cyc - h.g >= minl[l]);
            chk("gnt",    l, o_gnt[l],   egs[l]);
            chk("rvalid", l, o_rv[l],    evs[l]);
            chk("rdata",  l, o_rdata[l], (evs[l] && !h.we) ? rdat[l] : 32'd0);
            chk("err",    l, o_err[l],   (erren[l] != 0) && evs[l] && rerr[l]);
            chk("cnt",    l, o_cnt[l],   q[l].size());
            chk("raddr",  l, o_raddr[l], ne ? h.addr : 32'd0);
            chk("rwe",    l, o_rwe[l],   ne && h.we);
            chk("proto",  l, o_perr[l],  proto_m[l]);
        end
        @(posedge clock);
        #1;
        if (!reset) begin
            for (int l = 0; l < NL; l++) begin
                if (evs[l]) void'(q[l].pop_front());
                if (egs[l]) q[l].push_back('{addr: addr[l], we: we[l], be: be[l], g: cyc});
                if (pend_m[l] && (!req[l] || {addr[l], we[l], be[l]} != prev_m[l])) proto_m[l] = 1;
                pend_m[l] = req[l] && !egs[l];
                prev_m[l] = {addr[l], we[l], be[l]};
            end
        end
        cyc++;
    endtask

    task automatic idle_all();
        for (int l = 0; l < NL; l++) begin
            req[l] = 0; we[l] = 0; be[l] = 4'hF; addr[l] = 0;
            gen[l] = 1; ren[l] = 1; rerr[l] = 0; rdat[l] = $urandom;
        end
    endtask

    task automatic randomize_free();
        for (int l = 0; l < NL; l++) begin
            rdat[l] = $urandom;
            rerr[l] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        idle_all();
        for (int l = 0; l < NL; l++) begin req[l] = 1; rerr[l] = 1; end
        #1;
        step();
        step();
        // Release reset; everything must still be idle.
        idle_all();
        reset = 0;
        step();

        // Single read, MIN_LAT=1, lane 0.
        req[0] = 1; addr[0] = 32'h1A00_0080;
        step();
        chk("single_cnt1", 0, o_cnt[0], 1);
        req[0] = 0; rdat[0] = $urandom;
        step();
        chk("single_cnt0", 0, o_cnt[0], 0);

        // Back-pressure on lane 1: three requests, responses held off.
        ren[1] = 0; req[1] = 1; addr[1] = 32'h0000_1000; step();
        addr[1] = 32'h0000_2004; we[1] = 1; step();
        addr[1] = 32'h0000_3008; we[1] = 0; step();
        step();
        chk("bp_cnt", 1, o_cnt[1], 2);
        ren[1] = 1;
        for (int i = 0; i < 5; i++) begin
            randomize_free();
            if (i == 2) req[1] = 0;
            step();
        end

        // MIN_LAT=3 on lane 2, write with err allowed.
        req[2] = 1; addr[2] = 32'hCAFE_0010; we[2] = 1; rerr[2] = 1;
        step();
        req[2] = 0;
        for (int i = 0; i < 5; i++) step();

        // Protocol violation on lane 0: pending request whose address changes.
        req[0] = 1; gen[0] = 0; addr[0] = 32'h0000_0040; step();
        addr[0] = 32'h0000_0044; step();
        req[0] = 0; gen[0] = 1; step();
        chk("proto_set", 0, o_perr[0], 1);

        // Randomized traffic; requesters hold ungranted requests stable.
        for (int n = 0; n < 400; n++) begin
            for (int l = 0; l < NL; l++) begin
                if (!pend_m[l]) begin
                    req[l]  = 1'($urandom_range(0, 1));
                    addr[l] = $urandom;
                    we[l]   = 1'($urandom_range(0, 1));
                    be[l]   = 4'($urandom);
                end
                gen[l] = ($urandom_range(0, 3) != 0);
                ren[l] = ($urandom_range(0, 2) != 0);
            end
            randomize_free();
            step();
        end
        chk("proto_sticky", 0, o_perr[0], 1);

        // Reset with outstanding entries, then confirm nothing is returned for them.
        idle_all();
        for (int l = 0; l < NL; l++) begin ren[l] = 0; req[l] = 1; end
        addr[0] = 32'h10; addr[1] = 32'h20; addr[2] = 32'h30; step();
        addr[0] = 32'h14; addr[1] = 32'h24; addr[2] = 32'h34; step();
        reset = 1;
        step();
        reset = 0;
        idle_all();
        for (int i = 0; i < 5; i++) step();
        for (int l = 0; l < NL; l++) begin
            chk("post_rst_cnt", l, o_cnt[l], 0);
            chk("post_rst_proto", l, o_perr[l], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
